// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin, burst-locked arbiter sharing one FIFO write port between NUM_REQ streams.
// Latency : grant one cycle after a request is seen in IDLE; data path is combinational in BURST.
// Backpr. : wr_ready_i passes straight to the owner's ready; almost_full_i only blocks new bursts.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid_i     per-source valid
//   req_ready_o     per-source ready (only the owner's bit can be 1)
//   req_data_i      packed source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_valid_o      FIFO write valid
//   wr_ready_i      FIFO write ready
//   wr_data_o       FIFO write data, 0 outside a burst
//   almost_full_i   FIFO almost-full, sampled only when choosing a new owner
//   grant_o         one-hot owner, 0 when idle
//   busy_o          1 while a burst is in progress
//
// Build option
//   FIFO_ARB_PRIO0_EN : requester 0 wins every grant decision it takes part in;
//                       the rotation pointer only moves for the other requesters.
//                       Undefined (default): plain round-robin over all requesters.

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          wr_valid_o,
  input  logic                          wr_ready_i,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  input  logic                          almost_full_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]      rr_owner;
  logic                  rr_found;
  logic [IDX_W-1:0]      cand_idx;
  int                    cand;
  logic [IDX_W-1:0]      sel_owner;
  logic [IDX_W-1:0]      sel_ptr;
  logic                  owner_vld;
  logic [DATA_WIDTH-1:0] owner_dat;
  logic                  active;

  // ------------------------------------------------------------------
  // Round-robin search: first valid source after ptr, wrapping at NUM_REQ.
  // The search runs ptr+1 .. ptr+NUM_REQ so the previous owner is looked
  // at last, which is what gives the fairness.
  // ------------------------------------------------------------------
  always_comb begin
    rr_owner = ptr_q;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!rr_found && req_valid_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_owner = cand_idx;
      end
    end
  end

  // Owner selection at a grant decision, and where the pointer goes.
`ifdef FIFO_ARB_PRIO0_EN
  // Requester 0 jumps the queue but leaves the rotation untouched, so the
  // other requesters keep their round-robin order around it.
  always_comb begin
    if (req_valid_i[0]) begin
      sel_owner = '0;
      sel_ptr   = ptr_q;
    end else begin
      sel_owner = rr_owner;
      sel_ptr   = rr_owner;
    end
  end
`else
  always_comb begin
    sel_owner = rr_owner;
    sel_ptr   = rr_owner;
  end
`endif

  // ------------------------------------------------------------------
  // Owner mux: valid and data of the current owner.
  // ------------------------------------------------------------------
  always_comb begin
    owner_vld = 1'b0;
    owner_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_vld = req_valid_i[k];
        owner_dat = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // rst masks the port in the reset cycle itself so no beat slips through
  // while ownership is being torn down.
  assign active = (state_q == BURST) && !rst;

  assign busy_o     = active;
  assign wr_valid_o = active && owner_vld;
  assign wr_data_o  = active ? owner_dat : '0;

  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (active && (owner_q == IDX_W'(k))) begin
        grant_o[k]     = 1'b1;
        req_ready_o[k] = wr_ready_i;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      IDLE: begin
        // almost_full only gates the start of a burst.
        if ((|req_valid_i) && !almost_full_i) begin
          state_d    = BURST;
          owner_d    = sel_owner;
          ptr_d      = sel_ptr;
          beat_cnt_d = '0;
        end
      end

      BURST: begin
        if (!owner_vld) begin
          // Owner went quiet: release without transferring anything.
          state_d = IDLE;
        end else if (wr_ready_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // The beat that fills the quota is still transferred this cycle.
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
